ex_stage_mc: RTL and testbench
==============================

Name: ex_stage_mc

Overview:
- Parametrised execute stage: single-cycle ALU ops plus iterative multi-cycle divide and registered multiply, with signed and unsigned branch compare.
- Sits between decode and memory stages.
- valid/ready handshake on both sides so the divider can stall the pipe.
- Flush input kills the in-flight op on a taken branch or jump.

Parameters:
- XLEN, 32, datapath width in bits (even, ≥8).
- DIV_UNROLL, 1, quotient bits per divider cycle (1, 2 or 4; must divide XLEN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  kill in-flight op and output register.
- in_valid  in  1  operands/controls valid.
- in_ready  out  1  stage accepts an op this cycle.
- alu_op  in  4  ALU function (shared package encoding).
- md_op  in  3  MD_NONE / MUL / MULHU / DIV / DIVU / REM / REMU.
- b_sel  in  1  B_SEL_RD2 or B_SEL_EXT.
- br_op  in  3  BR_NONE / EQ / NE / LT / GE / LTU / GEU.
- A  in  XLEN  operand A.
- rf_rD2  in  XLEN  register operand.
- sext_ext  in  XLEN  immediate.
- out_valid  out  1  C/f valid.
- out_ready  in  1  downstream accepts.
- C  out  XLEN  result.
- f  out  1  branch-taken flag.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, out_valid=0, C=0, f=0.
  - in_ready is low during reset.
- Operand B:
  - b_sel=B_SEL_RD2 gives rf_rD2; B_SEL_EXT gives sext_ext.
  - Registered into op latch on accept.
- Accept: in_valid && in_ready at posedge.
- in_ready is high only when state=IDLE && (!out_valid || out_ready) && !flush.
- md_op=MD_NONE:
  - C = ALU(alu_op, A, B); f from br_op.
  - Latency 1: out_valid high the cycle after accept.
- MUL / MULHU:
  - Full 2*XLEN unsigned product, registered. MUL returns the low half, MULHU the high half.
  - Latency 1.
- DIV / DIVU / REM / REMU:
  - state IDLE→BUSY on accept.
  - Divider runs XLEN/DIV_UNROLL cycles, then BUSY→IDLE with out_valid=1.
  - Latency XLEN/DIV_UNROLL+1 cycles from accept.
- Divide special cases, detected at accept; take 1-cycle latency and skip BUSY:
  - B=0: quotient all-ones, remainder = A.
  - Signed, A=MIN, B=-1: quotient MIN, remainder 0.
- Signed divide: operate on magnitudes.
  - Quotient negated if sign(A)≠sign(B).
  - Remainder takes sign(A).
- Branch flag f, with dif = A−B over XLEN bits:
  - EQ/NE from dif==0.
  - LT/GE signed compare; LTU/GEU unsigned compare (carry-out of A−B).
  - BR_NONE gives f=0.
  - f is valid with out_valid and 0 for MD ops.
- Output hold: C, f, out_valid stay stable while out_valid && !out_ready.
- Pop: out_valid && out_ready with no new accept clears out_valid.
- Pop and accept in the same cycle: out_valid stays 1 with the new single-cycle result (back-to-back, one result per cycle).
- Flush, sync, highest priority below reset:
  - out_valid←0, state←IDLE, divider aborted, no accept that cycle.
- Flush during BUSY: divider result discarded. The next op is accepted the cycle after flush deasserts.
- All arithmetic is mod 2^XLEN. No exceptions or overflow flags.

Decomposition:
- Shared package holds:
  - ALU_* opcodes (4-bit), MD_* (3-bit), BR_* (3-bit), B_SEL_RD2/B_SEL_EXT.
  - Divider state enum {IDLE, BUSY}.
- Existing ALU module is instantiated unchanged, widened via XLEN.
- One sub-module is natural: div_iter.
  - Parameters XLEN, DIV_UNROLL.
  - Ports: start, a, b, signed_op, busy, done, quo, rem, abort.
  - Restoring algorithm.

Test Plan:
- ALU ADD, A=5, B_SEL_EXT imm=0xFFFFFFFB, out_ready=1: C=0 one cycle after accept, out_valid=1 for one cycle. Back-to-back ADDs give one result per cycle.
- Branch compare, A=0xFFFFFFFF, B=1: LT gives f=1, LTU gives f=0. EQ with A=B=0x1234 gives f=1; NE gives f=0.
- DIV A=-7, B=2, XLEN=32, DIV_UNROLL=1: in_ready low 32 cycles, then C=-3 (0xFFFFFFFD). REM of the same operands gives C=-1.
- DIVU by zero, A=0x55: C=0xFFFFFFFF after 1 cycle. DIV 0x80000000/-1 gives C=0x80000000; REM gives 0.
- Backpressure: out_ready=0 for 5 cycles after MUL 0x10000×0x10000. MUL holds C=0, MULHU holds C=1, stable throughout. in_ready stays low; release gives a one-cycle pop.
- flush asserted at BUSY cycle 10 of a DIVU: out_valid never rises, in_ready high the next cycle. rst_n=0 mid-BUSY gives out_valid=0, C=0, f=0.

Source files
------------

// File: rtl/ex_stage_mc_pkg.sv
// Shared encodings for the execute stage: ALU, multiply/divide, branch and operand-select codes.
package ex_stage_mc_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLL    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_SLT    = 4'd8;
    localparam logic [3:0] ALU_SLTU   = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MUL   = 3'd1;
    localparam logic [2:0] MD_MULHU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_REM   = 3'd5;
    localparam logic [2:0] MD_REMU  = 3'd6;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_EQ   = 3'd1;
    localparam logic [2:0] BR_NE   = 3'd2;
    localparam logic [2:0] BR_LT   = 3'd3;
    localparam logic [2:0] BR_GE   = 3'd4;
    localparam logic [2:0] BR_LTU  = 3'd5;
    localparam logic [2:0] BR_GEU  = 3'd6;

    localparam logic B_SEL_RD2 = 1'b0;
    localparam logic B_SEL_EXT = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } div_state_t;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
    endfunction

    function automatic logic is_signed_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic is_rem_op(input logic [2:0] op);
        return (op == MD_REM) || (op == MD_REMU);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU shared across pipeline stages, width set by XLEN.
module alu
    import ex_stage_mc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    localparam int SHW = $clog2(XLEN);

    // Select the arithmetic, logic, shift or compare result for alu_op.
    always_comb begin
        y = '0;
        case (alu_op)
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_AND:    y = a & b;
            ALU_OR:     y = a | b;
            ALU_XOR:    y = a ^ b;
            ALU_SLL:    y = a << b[SHW-1:0];
            ALU_SRL:    y = a >> b[SHW-1:0];
            ALU_SRA:    y = $unsigned($signed(a) >>> b[SHW-1:0]);
            ALU_SLT:    y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:   y = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_PASS_B: y = b;
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage_mc_div_iter.sv
// Iterative restoring divider on operand magnitudes, DIV_UNROLL quotient bits per cycle.
// done is high during the final iteration; quo/rem then carry the sign-corrected result.
module ex_stage_mc_div_iter #(
    parameter int XLEN       = 32,
    parameter int DIV_UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            signed_op,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);

    localparam int STEPS = XLEN / DIV_UNROLL;
    localparam int CW    = $clog2(STEPS + 1);

    logic [CW-1:0]   count;
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] acc_r;
    logic [XLEN-1:0] div_b;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] q_step;
    logic [XLEN-1:0] r_step;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;

    assign a_mag = (signed_op && a[XLEN-1]) ? -a : a;
    assign b_mag = (signed_op && b[XLEN-1]) ? -b : b;

    // Perform DIV_UNROLL shift-subtract-restore steps on the current partial remainder.
    always_comb begin
        q_step  = acc_q;
        r_step  = acc_r;
        shifted = '0;
        trial   = '0;
        for (int i = 0; i < DIV_UNROLL; i++) begin
            shifted = {r_step, q_step[XLEN-1]};
            trial   = shifted - {1'b0, div_b};
            q_step  = {q_step[XLEN-2:0], ~trial[XLEN]};
            r_step  = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        end
    end

    assign done = busy && (count == CW'(1));
    assign quo  = neg_q ? -q_step : q_step;
    assign rem  = neg_r ? -r_step : r_step;

    // Load magnitudes and signs on start, iterate while busy, drop everything on abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            count <= '0;
            acc_q <= '0;
            acc_r <= '0;
            div_b <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (abort) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= CW'(STEPS);
            acc_q <= a_mag;
            acc_r <= '0;
            div_b <= b_mag;
            neg_q <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
            neg_r <= signed_op && a[XLEN-1];
        end else if (busy) begin
            acc_q <= q_step;
            acc_r <= r_step;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: single-cycle ALU, registered multiply, iterative divide and branch compare,
// with valid/ready on both sides so a running divide stalls the pipe.
module ex_stage_mc
    import ex_stage_mc_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [2:0]      md_op,
    input  logic            b_sel,
    input  logic [2:0]      br_op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] rf_rD2,
    input  logic [XLEN-1:0] sext_ext,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] C,
    output logic            f
);

    localparam int              PW      = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state;
    div_state_t      state_next;
    logic [XLEN-1:0] b_op;
    logic [XLEN-1:0] alu_y;
    logic [XLEN-1:0] single_c;
    logic            single_f;
    logic [PW-1:0]   product;
    logic [XLEN:0]   dif;
    logic            br_f;
    logic            b_zero;
    logic            div_op;
    logic            div_special;
    logic            accept;
    logic            div_start;
    logic            div_busy;
    logic            div_done;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_rem;
    logic            rem_sel;

    // Choose operand B from the register file or the sign-extended immediate.
    always_comb begin
        b_op = rf_rD2;
        case (b_sel)
            B_SEL_RD2: b_op = rf_rD2;
            B_SEL_EXT: b_op = sext_ext;
            default:   b_op = rf_rD2;
        endcase
    end

    alu #(.XLEN(XLEN)) u_alu (
        .alu_op (alu_op),
        .a      (A),
        .b      (b_op),
        .y      (alu_y)
    );

    assign product     = PW'(A) * PW'(b_op);
    assign dif         = {1'b0, A} - {1'b0, b_op};
    assign b_zero      = (b_op == '0);
    assign div_op      = is_div_op(md_op);
    assign div_special = div_op && (b_zero ||
                         (is_signed_div(md_op) && (A == MIN_INT) && (b_op == '1)));

    // Branch flag from the difference: zero test, sign with overflow fix-up, and borrow.
    always_comb begin
        br_f = 1'b0;
        case (br_op)
            BR_NONE: br_f = 1'b0;
            BR_EQ:   br_f = (dif[XLEN-1:0] == '0);
            BR_NE:   br_f = (dif[XLEN-1:0] != '0);
            BR_LT:   br_f = (A[XLEN-1] != b_op[XLEN-1]) ? A[XLEN-1] : dif[XLEN-1];
            BR_GE:   br_f = !((A[XLEN-1] != b_op[XLEN-1]) ? A[XLEN-1] : dif[XLEN-1]);
            BR_LTU:  br_f = dif[XLEN];
            BR_GEU:  br_f = !dif[XLEN];
            default: br_f = 1'b0;
        endcase
    end

    // Result for every op that completes in one cycle, including the divide special cases.
    always_comb begin
        single_c = alu_y;
        case (md_op)
            MD_MUL:          single_c = product[XLEN-1:0];
            MD_MULHU:        single_c = product[PW-1:XLEN];
            MD_DIV, MD_DIVU: single_c = b_zero ? '1 : A;
            MD_REM, MD_REMU: single_c = b_zero ? A : '0;
            default:         single_c = alu_y;
        endcase
        single_f = (md_op == MD_NONE) && br_f;
    end

    ex_stage_mc_div_iter #(
        .XLEN       (XLEN),
        .DIV_UNROLL (DIV_UNROLL)
    ) u_div_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .abort     (flush),
        .a         (A),
        .b         (b_op),
        .signed_op (is_signed_div(md_op)),
        .busy      (div_busy),
        .done      (div_done),
        .quo       (div_quo),
        .rem       (div_rem)
    );

    // Divider state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake and next state: only IDLE with a free output slot and no flush accepts.
    always_comb begin
        state_next = state;
        in_ready   = rst_n && (state == IDLE) && !div_busy && (!out_valid || out_ready) && !flush;
        accept     = in_valid && in_ready;
        div_start  = accept && div_op && !div_special;
        case (state)
            IDLE:    if (div_start) state_next = BUSY;
            BUSY:    if (flush || div_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output register: flush kills, accepts load or start a divide, divider completion loads, pops clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            C         <= '0;
            f         <= 1'b0;
            rem_sel   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            if (div_start) begin
                out_valid <= 1'b0;
                rem_sel   <= is_rem_op(md_op);
            end else begin
                out_valid <= 1'b1;
                C         <= single_c;
                f         <= single_f;
            end
        end else if (div_done) begin
            out_valid <= 1'b1;
            C         <= rem_sel ? div_rem : div_quo;
            f         <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Bench for ex_stage_mc: directed vector table, random ops against an arithmetic model,
// and hand sequences for back-to-back, backpressure, flush and reset during a divide.
module tb_ex_stage_mc;
    import ex_stage_mc_pkg::*;

    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, b_sel, out_valid, out_ready, f;
    logic [3:0]  alu_op;
    logic [2:0]  md_op, br_op;
    logic [31:0] A, rf_rD2, sext_ext, C;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        string       name;
        logic [3:0]  aop;
        logic [2:0]  mop;
        logic [2:0]  bop;
        logic        bs;
        logic [31:0] a;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [31:0] exp_c;
        logic        exp_f;
        int          exp_lat;
    } vec_t;

    vec_t vecs [19];

    always #5 clk = ~clk;

    ex_stage_mc #(.XLEN(32), .DIV_UNROLL(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .md_op     (md_op),
        .b_sel     (b_sel),
        .br_op     (br_op),
        .A         (A),
        .rf_rD2    (rf_rD2),
        .sext_ext  (sext_ext),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .f         (f)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input string name, input logic [3:0] aop, input logic [2:0] mop,
                                   input logic [2:0] bop, input logic bs, input logic [31:0] a,
                                   input logic [31:0] rd2, input logic [31:0] ext,
                                   input logic [31:0] exp_c, input logic exp_f, input int exp_lat);
        vec_t v;
        v.name = name; v.aop = aop; v.mop = mop; v.bop = bop; v.bs = bs;
        v.a = a; v.rd2 = rd2; v.ext = ext; v.exp_c = exp_c; v.exp_f = exp_f; v.exp_lat = exp_lat;
        return v;
    endfunction

    function automatic logic [31:0] modelC(input logic [3:0] aop, input logic [2:0] mop,
                                           input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        longint unsigned    ua, ub, prod;
        logic [4:0]         sh;
        logic               ovf;
        sa = a; sb = b; ua = a; ub = b; prod = ua * ub; sh = b[4:0];
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (mop)
            MD_MUL:   return prod[31:0];
            MD_MULHU: return prod[63:32];
            MD_DIV:   begin if (b == 0) return 32'hFFFF_FFFF; if (ovf) return 32'h8000_0000; return sa / sb; end
            MD_DIVU:  begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            MD_REM:   begin if (b == 0) return a; if (ovf) return 32'h0; return sa % sb; end
            MD_REMU:  begin if (b == 0) return a; return a % b; end
            default: begin
                case (aop)
                    ALU_ADD:    return a + b;
                    ALU_SUB:    return a - b;
                    ALU_AND:    return a & b;
                    ALU_OR:     return a | b;
                    ALU_XOR:    return a ^ b;
                    ALU_SLL:    return a << sh;
                    ALU_SRL:    return a >> sh;
                    ALU_SRA:    return sa >>> sh;
                    ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
                    ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
                    ALU_PASS_B: return b;
                    default:    return 32'd0;
                endcase
            end
        endcase
    endfunction

    function automatic logic modelF(input logic [2:0] bop, input logic [2:0] mop,
                                    input logic [31:0] a, input logic [31:0] b);
        if (mop != MD_NONE) return 1'b0;
        case (bop)
            BR_EQ:  return a == b;
            BR_NE:  return a != b;
            BR_LT:  return $signed(a) < $signed(b);
            BR_GE:  return $signed(a) >= $signed(b);
            BR_LTU: return a < b;
            BR_GEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int modelLat(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b);
        logic is_div, sgn;
        is_div = (mop == MD_DIV) || (mop == MD_DIVU) || (mop == MD_REM) || (mop == MD_REMU);
        sgn    = (mop == MD_DIV) || (mop == MD_REM);
        if (!is_div || b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return DIV_LAT;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] aop, input logic [2:0] mop, input logic [2:0] bop,
                                 input logic bs, input logic [31:0] a_v, input logic [31:0] rd2_v,
                                 input logic [31:0] ext_v, output logic [31:0] c_o, output logic f_o,
                                 output int lat_o);
        int guard;
        @(negedge clk);
        alu_op = aop; md_op = mop; br_op = bop; b_sel = bs;
        A = a_v; rf_rD2 = rd2_v; sext_ext = ext_v;
        in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat_o = 1;
        while (!out_valid && lat_o < 100) begin
            @(posedge clk);
            #1;
            lat_o++;
        end
        c_o = C;
        f_o = f;
    endtask

    initial begin
        logic [31:0] c_got, a_r, rd2_r, ext_r, b_eff;
        logic        f_got, bs_r, seen;
        logic [3:0]  aop_r;
        logic [2:0]  mop_r, bop_r;
        int          lat;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = ALU_ADD; md_op = MD_NONE; br_op = BR_NONE; b_sel = B_SEL_RD2;
        A = 32'h0; rf_rD2 = 32'h0; sext_ext = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_c", C, 32'd0);
        checkOutput("reset_f", 32'(f), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

        vecs[0]  = mkVec("add_imm",  ALU_ADD,  MD_NONE,  BR_NONE, B_SEL_EXT, 32'd5,          32'h77,         32'hFFFF_FFFB, 32'h0,          1'b0, 1);
        vecs[1]  = mkVec("sub",      ALU_SUB,  MD_NONE,  BR_NONE, B_SEL_RD2, 32'd3,          32'd5,          32'h0,         32'hFFFF_FFFE,  1'b0, 1);
        vecs[2]  = mkVec("blt",      ALU_ADD,  MD_NONE,  BR_LT,   B_SEL_RD2, 32'hFFFF_FFFF,  32'd1,          32'h0,         32'h0,          1'b1, 1);
        vecs[3]  = mkVec("bltu",     ALU_ADD,  MD_NONE,  BR_LTU,  B_SEL_RD2, 32'hFFFF_FFFF,  32'd1,          32'h0,         32'h0,          1'b0, 1);
        vecs[4]  = mkVec("bge",      ALU_ADD,  MD_NONE,  BR_GE,   B_SEL_RD2, 32'hFFFF_FFFF,  32'd1,          32'h0,         32'h0,          1'b0, 1);
        vecs[5]  = mkVec("bgeu",     ALU_ADD,  MD_NONE,  BR_GEU,  B_SEL_RD2, 32'hFFFF_FFFF,  32'd1,          32'h0,         32'h0,          1'b1, 1);
        vecs[6]  = mkVec("beq",      ALU_ADD,  MD_NONE,  BR_EQ,   B_SEL_RD2, 32'h1234,       32'h1234,       32'h0,         32'h2468,       1'b1, 1);
        vecs[7]  = mkVec("bne",      ALU_ADD,  MD_NONE,  BR_NE,   B_SEL_RD2, 32'h1234,       32'h1234,       32'h0,         32'h2468,       1'b0, 1);
        vecs[8]  = mkVec("div_neg",  ALU_ADD,  MD_DIV,   BR_NONE, B_SEL_RD2, 32'hFFFF_FFF9,  32'd2,          32'h0,         32'hFFFF_FFFD,  1'b0, DIV_LAT);
        vecs[9]  = mkVec("rem_neg",  ALU_ADD,  MD_REM,   BR_NONE, B_SEL_RD2, 32'hFFFF_FFF9,  32'd2,          32'h0,         32'hFFFF_FFFF,  1'b0, DIV_LAT);
        vecs[10] = mkVec("divu_z",   ALU_ADD,  MD_DIVU,  BR_NONE, B_SEL_RD2, 32'h55,         32'h0,          32'h0,         32'hFFFF_FFFF,  1'b0, 1);
        vecs[11] = mkVec("remu_z",   ALU_ADD,  MD_REMU,  BR_NONE, B_SEL_RD2, 32'h55,         32'h0,          32'h0,         32'h55,         1'b0, 1);
        vecs[12] = mkVec("div_ovf",  ALU_ADD,  MD_DIV,   BR_NONE, B_SEL_RD2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,         32'h8000_0000,  1'b0, 1);
        vecs[13] = mkVec("rem_ovf",  ALU_ADD,  MD_REM,   BR_NONE, B_SEL_RD2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,         32'h0,          1'b0, 1);
        vecs[14] = mkVec("mul",      ALU_ADD,  MD_MUL,   BR_NONE, B_SEL_RD2, 32'h1_0000,     32'h1_0000,     32'h0,         32'h0,          1'b0, 1);
        vecs[15] = mkVec("mulhu",    ALU_ADD,  MD_MULHU, BR_NONE, B_SEL_RD2, 32'h1_0000,     32'h1_0000,     32'h0,         32'h1,          1'b0, 1);
        vecs[16] = mkVec("divu_ext", ALU_ADD,  MD_DIVU,  BR_NONE, B_SEL_EXT, 32'd100,        32'h0,          32'd7,         32'd14,         1'b0, DIV_LAT);
        vecs[17] = mkVec("sra",      ALU_SRA,  MD_NONE,  BR_NONE, B_SEL_RD2, 32'h8000_0000,  32'd4,          32'h0,         32'hF800_0000,  1'b0, 1);
        vecs[18] = mkVec("mul_br",   ALU_ADD,  MD_MUL,   BR_EQ,   B_SEL_RD2, 32'd3,          32'd3,          32'h0,         32'd9,          1'b0, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].aop, vecs[i].mop, vecs[i].bop, vecs[i].bs, vecs[i].a,
                          vecs[i].rd2, vecs[i].ext, c_got, f_got, lat);
            checkOutput({vecs[i].name, "_c"}, c_got, vecs[i].exp_c);
            checkOutput({vecs[i].name, "_f"}, 32'(f_got), 32'(vecs[i].exp_f));
            checkOutput({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
        end

        for (int i = 0; i < 30; i++) begin
            aop_r = 4'($urandom_range(0, 10));
            mop_r = 3'($urandom_range(0, 6));
            bop_r = 3'($urandom_range(0, 6));
            bs_r  = 1'($urandom_range(0, 1));
            a_r   = pickOperand();
            rd2_r = pickOperand();
            ext_r = pickOperand();
            b_eff = bs_r ? ext_r : rd2_r;
            applyStimulus(aop_r, mop_r, bop_r, bs_r, a_r, rd2_r, ext_r, c_got, f_got, lat);
            checkOutput($sformatf("rnd%0d_c", i), c_got, modelC(aop_r, mop_r, a_r, b_eff));
            checkOutput($sformatf("rnd%0d_f", i), 32'(f_got), 32'(modelF(bop_r, mop_r, a_r, b_eff)));
            checkOutput($sformatf("rnd%0d_lat", i), 32'(lat), 32'(modelLat(mop_r, a_r, b_eff)));
        end

        @(negedge clk);
        out_ready = 1'b1; alu_op = ALU_ADD; md_op = MD_NONE; br_op = BR_NONE;
        b_sel = B_SEL_EXT; sext_ext = 32'd2; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            A = 32'(i * 10 + 1);
            checkOutput($sformatf("b2b%0d_ready", i), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("b2b%0d_c", i), C, 32'(i * 10 + 3));
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("b2b_pop", 32'(out_valid), 32'd0);

        @(negedge clk);
        md_op = MD_MUL; b_sel = B_SEL_RD2; A = 32'h1_0000; rf_rD2 = 32'h1_0000;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        md_op = MD_MULHU;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_mul%0d_valid", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp_mul%0d_c", k), C, 32'h0);
            checkOutput($sformatf("bp_mul%0d_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_swap_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_mulhu_c", C, 32'h1);
        in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_mulhu%0d_c", k), C, 32'h1);
            checkOutput($sformatf("bp_mulhu%0d_valid", k), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_pop", 32'(out_valid), 32'd0);

        @(negedge clk);
        md_op = MD_DIVU; A = 32'd1000; rf_rD2 = 32'd3; b_sel = B_SEL_RD2; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkOutput("flush_busy_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        checkOutput("flush_next_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checkOutput("flush_no_result", 32'(seen), 32'd0);

        applyStimulus(ALU_ADD, MD_NONE, BR_EQ, B_SEL_RD2, 32'd5, 32'd5, 32'h0, c_got, f_got, lat);
        checkOutput("pre_reset_c", c_got, 32'd10);
        checkOutput("pre_reset_f", 32'(f_got), 32'd1);
        @(negedge clk);
        md_op = MD_DIV; A = 32'd100; rf_rD2 = 32'd7; b_sel = B_SEL_RD2; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("busy_reset_valid", 32'(out_valid), 32'd0);
        checkOutput("busy_reset_c", C, 32'd0);
        checkOutput("busy_reset_f", 32'(f), 32'd0);
        checkOutput("busy_reset_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("after_reset_ready", 32'(in_ready), 32'd1);
        applyStimulus(ALU_ADD, MD_NONE, BR_NONE, B_SEL_RD2, 32'd2, 32'd3, 32'h0, c_got, f_got, lat);
        checkOutput("after_reset_c", c_got, 32'd5);
        checkOutput("after_reset_lat", 32'(lat), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
